// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the dmem_resp data-memory responder.
// FSM encodings, reset polarity, default geometry and an address range helper.
package dmem_resp_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_WAIT_CYCLES = 2;

    // reset_ is active-low
    localparam logic RST_ASSERT = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // True when the byte address lies beyond the 2**aw word array
    function automatic logic addr_oob(input logic [31:0] a, input int aw);
        return (a >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: byte-lane writes, registered (synchronous) read.
// Contents are never reset.
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_re,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    // Per-lane store into the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read of the full word
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: req/ack access FSM in front of dmem_ram.
// Optional wait states are compiled in with `define DMEM_WAIT_EN.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);

`ifdef DMEM_WAIT_EN
    localparam bit LP_WAIT_EN = (WAIT_CYCLES > 0);
    localparam int CNT_W =
        (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
`else
    // Wait states compiled out; WAIT_CYCLES only keeps the interface uniform
    localparam bit LP_WAIT_EN = 1'b0 && (WAIT_CYCLES >= 0);
`endif

    state_t            r_state;
    state_t            w_next;

    logic              r_we;
    logic              r_err;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_idx;

    logic              w_accept;
    logic              w_ram_re;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_q;

    assign w_accept = (r_state == S_IDLE) && req;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = LP_WAIT_EN ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
`ifdef DMEM_WAIT_EN
                if (r_cnt <= CNT_W'(1)) begin
                    w_next = S_RESP;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_) begin
        if (reset_ == RST_ASSERT) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the request at acceptance; later input changes are ignored
    always_ff @(posedge clk or negedge reset_) begin
        if (reset_ == RST_ASSERT) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_we    <= we;
            r_err   <= addr_oob(addr, ADDR_W);
            r_be    <= be;
            r_wdata <= wdata;
            r_idx   <= addr[ADDR_W+1:2];
        end
    end

`ifdef DMEM_WAIT_EN
    // Wait-state countdown, loaded at acceptance
    always_ff @(posedge clk or negedge reset_) begin
        if (reset_ == RST_ASSERT) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
`endif

    // RAM read fires on the edge entering RESP; on a direct
    // IDLE->RESP step the index is not captured yet, so use the port.
    assign w_ram_re   = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_ram_addr = (r_state == S_IDLE) ? addr[ADDR_W+1:2] : r_idx;

    // Store commits on the edge that closes the ack cycle
    assign w_ram_we   = (r_state == S_RESP) && r_we && !r_err;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_be    (r_be),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    assign ack   = (r_state == S_RESP);
    assign err   = ack && r_err;
    assign rdata = (ack && !r_we && !r_err) ? w_ram_q : 32'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp against a word-array reference model.
// Honours DMEM_WAIT_EN (runs the DUT with WAIT_CYCLES=3 in that build).
module tb_dmem_resp;

    localparam int AW = 8;
    localparam int WC = 3;
    localparam int DEPTH = 1 << AW;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 1 + WC;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_resp #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .be     (be),
        .wdata  (wdata),
        .ack    (ack),
        .err    (err),
        .rdata  (rdata)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
        return a >= (32'd1 << (AW + 2));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  b);
        logic [31:0] m;
        m = 32'd0;
        if (b[0]) m = m | 32'h0000_00FF;
        if (b[1]) m = m | 32'h0000_FF00;
        if (b[2]) m = m | 32'h00FF_0000;
        if (b[3]) m = m | 32'hFF00_0000;
        return (old & ~m) | (nw & m);
    endfunction

    // One access from an IDLE cycle; ends at the negedge of the ack cycle
    task automatic access(input bit          w,
                          input logic [31:0] a,
                          input logic [3:0]  b,
                          input logic [31:0] d,
                          input bit          noisy,
                          input string       tag,
                          output logic [31:0] o_rd,
                          output logic        o_err);
        int          got_lat;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_rd;
        @(negedge clk);
        chk({tag, "/ack_idle"}, {31'd0, ack}, 32'd0);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        idx     = int'((a >> 2) % DEPTH);
        exp_err = oob(a);
        exp_rd  = (w || exp_err) ? 32'd0 : model[idx];
        o_rd    = 32'd0;
        o_err   = 1'b0;
        @(posedge clk);
        #1;
        if (noisy) begin
            req   = 1'($urandom);
            we    = 1'($urandom);
            addr  = $urandom;
            be    = 4'($urandom);
            wdata = $urandom;
        end
        got_lat = -1;
        for (int c = 1; c <= LAT + 4 && got_lat < 0; c++) begin
            @(negedge clk);
            if (ack) begin
                got_lat = c;
                o_rd  = rdata;
                o_err = err;
                chk({tag, "/err"}, {31'd0, err}, {31'd0, exp_err});
                chk({tag, "/rdata"}, rdata, exp_rd);
            end else begin
                chk({tag, "/rd_noack"}, rdata, 32'd0);
            end
        end
        req = 1'b0;
        chk({tag, "/lat"}, 32'(got_lat), 32'(LAT));
        if (w && !exp_err && got_lat > 0) begin
            model[idx] = merge(model[idx], d, b);
        end
    endtask

    // req held high: one access every LAT+1 cycles
    task automatic back2back(input logic [31:0] a);
        int          idx;
        bit          exp_ack;
        idx = int'((a >> 2) % DEPTH);
        @(negedge clk);
        chk("b2b/ack_idle", {31'd0, ack}, 32'd0);
        req   = 1'b1;
        we    = 1'b0;
        addr  = a;
        be    = 4'b0000;
        wdata = 32'd0;
        for (int c = 1; c <= 3 * (LAT + 1) - 1; c++) begin
            @(negedge clk);
            exp_ack = (c % (LAT + 1)) == LAT;
            chk("b2b/ack", {31'd0, ack}, {31'd0, exp_ack});
            chk("b2b/rdata", rdata, exp_ack ? model[idx] : 32'd0);
        end
        req = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset_ = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        addr   = 32'd0;
        be     = 4'b0000;
        wdata  = 32'd0;
        #12;
        chk("rst/ack", {31'd0, ack}, 32'd0);
        chk("rst/err", {31'd0, err}, 32'd0);
        chk("rst/rdata", rdata, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 32'(i) << 2, 4'hF, $urandom, 1'b0, "init", rd, er);
        end

        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "s10", rd, er);
        access(1'b0, 32'h10, 4'h0, 32'd0, 1'b0, "l10", rd, er);
        chk("l10/word", rd, 32'hDEADBEEF);
        chk("l10/err0", {31'd0, er}, 32'd0);

        access(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, "s20a", rd, er);
        access(1'b1, 32'h20, 4'h2, 32'h0000AA00, 1'b0, "s20b", rd, er);
        access(1'b0, 32'h23, 4'h0, 32'd0, 1'b0, "l20", rd, er);
        chk("l20/word", rd, 32'h1122AA44);

        access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, "s20z", rd, er);
        access(1'b0, 32'h20, 4'h0, 32'd0, 1'b0, "l20z", rd, er);
        chk("l20z/word", rd, 32'h1122AA44);

        access(1'b0, 32'h1000, 4'h0, 32'd0, 1'b0, "loob", rd, er);
        chk("loob/err", {31'd0, er}, 32'd1);
        chk("loob/rd", rd, 32'd0);
        access(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, "soob", rd, er);
        chk("soob/err", {31'd0, er}, 32'd1);
        access(1'b0, 32'h0, 4'h0, 32'd0, 1'b0, "l0", rd, er);

        back2back(32'h10);

        // Reset one cycle into a store to 0x30
        @(negedge clk);
        chk("rstmid/ack_idle", {31'd0, ack}, 32'd0);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h30;
        be    = 4'hF;
        wdata = ~model[12];
        @(posedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        req = 1'b0;
        chk("rstmid/ack", {31'd0, ack}, 32'd0);
        chk("rstmid/err", {31'd0, err}, 32'd0);
        chk("rstmid/rdata", rdata, 32'd0);
        @(negedge clk);
        chk("rstmid/ack2", {31'd0, ack}, 32'd0);
        reset_ = 1'b1;
        access(1'b0, 32'h30, 4'h0, 32'd0, 1'b0, "l30", rd, er);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {22'd0, 8'($urandom), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) begin
                a = a | (32'd1 << (AW + 2 + $urandom_range(0, 21)));
            end
            access(1'($urandom), a, 4'($urandom), $urandom,
                   1'b1, "rnd", rd, er);
        end

        @(negedge clk);
        chk("end/ack", {31'd0, ack}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
